// File: rtl/ddr_test_uart_report.sv
// Status reporter for the DDR3 pattern tester: sends 14-byte ASCII lines over a UART (8N1).
// Optional macro DDR_REPORT_VERDICT_EN replaces the 'D' flag with a P/F verdict against EXPECTED_OK.
module ddr_test_uart_report #(
  parameter int          CLKS_PER_BIT  = 434,
  parameter int          REPORT_PERIOD = 50000000,
  parameter logic [23:0] EXPECTED_OK   = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wdone,
  input  logic        rdone,
  input  logic [23:0] num_ok,
  input  logic [2:0]  test_state,
  output logic        uart_tx,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for a pending report
  // LOAD  | one cycle: latch snapshot, clear pending, restart period count
  // START | start bit (low)
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (high); then next byte or end of line
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [31:0] PER_LAST  = (REPORT_PERIOD == 0) ? 32'd0 : 32'(REPORT_PERIOD - 1);

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  byte_q, byte_d;
  logic [2:0]  snap_state_q;
  logic [23:0] snap_ok_q;
  logic        snap_w_q, snap_r_q;

  logic [31:0] per_base;
  logic        per_expire;
  logic        state_chg;
  logic        baud_done;
  logic [3:0]  nib;
  logic [7:0]  flag;
  logic [7:0]  cur_byte;

  // The LOAD cycle itself counts as period count 0, so line starts land exactly REPORT_PERIOD apart.
  always_comb begin
    per_base   = (state_q == LOAD) ? 32'd0 : per_cnt_q;
    per_expire = 1'b0;
    per_cnt_d  = per_base + 32'd1;
    if (REPORT_PERIOD == 0) begin
      per_cnt_d = 32'd0;
    end else if (per_base == PER_LAST) begin
      per_expire = 1'b1;
      per_cnt_d  = 32'd0;
    end
  end

  // During LOAD the snapshot is being replaced; the change is re-detected against the new one next cycle.
  assign state_chg = (state_q != LOAD) && (test_state != snap_state_q);
  assign pending_d = (pending_q && (state_q != LOAD)) || state_chg || per_expire;
  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    case (state_q)
      IDLE: begin
        if (pending_d) state_d = LOAD;
      end
      LOAD: begin
        state_d = START;
        baud_d  = 16'd0;
        bit_d   = 3'd0;
        byte_d  = 4'd0;
      end
      START: begin
        if (baud_done) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = 16'd0;
          if (byte_q == 4'd13) begin
            state_d = pending_d ? LOAD : IDLE;
          end else begin
            byte_d  = byte_q + 4'd1;
            state_d = START;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= 1'b1;
      per_cnt_q    <= 32'd0;
      baud_q       <= 16'd0;
      bit_q        <= 3'd0;
      byte_q       <= 4'd0;
      snap_state_q <= 3'd0;
      snap_ok_q    <= 24'd0;
      snap_w_q     <= 1'b0;
      snap_r_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      per_cnt_q <= per_cnt_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      if (state_q == LOAD) begin
        snap_state_q <= test_state;
        snap_ok_q    <= num_ok;
        snap_w_q     <= wdone;
        snap_r_q     <= rdone;
      end
    end
  end

`ifdef DDR_REPORT_VERDICT_EN
  always_comb begin
    if (snap_r_q)      flag = (snap_ok_q == EXPECTED_OK) ? "P" : "F";
    else if (snap_w_q) flag = "W";
    else               flag = "-";
  end
`else
  logic unused_exp_ok;
  assign unused_exp_ok = ^EXPECTED_OK;
  always_comb begin
    if (snap_r_q)      flag = "D";
    else if (snap_w_q) flag = "W";
    else               flag = "-";
  end
`endif

  always_comb begin
    case (byte_q)
      4'd4:    nib = snap_ok_q[23:20];
      4'd5:    nib = snap_ok_q[19:16];
      4'd6:    nib = snap_ok_q[15:12];
      4'd7:    nib = snap_ok_q[11:8];
      4'd8:    nib = snap_ok_q[7:4];
      default: nib = snap_ok_q[3:0];
    endcase
  end

  always_comb begin
    case (byte_q)
      4'd0:                         cur_byte = "S";
      4'd1:                         cur_byte = 8'h30 + {5'd0, snap_state_q};
      4'd2, 4'd10:                  cur_byte = " ";
      4'd3:                         cur_byte = "N";
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
      4'd9:                         cur_byte = (nib < 4'd10) ? (8'h30 + {4'd0, nib})
                                                             : (8'h37 + {4'd0, nib});
      4'd11:                        cur_byte = flag;
      4'd12:                        cur_byte = 8'h0D;
      4'd13:                        cur_byte = 8'h0A;
      default:                      cur_byte = 8'hFF;
    endcase
  end

  always_comb begin
    case (state_q)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = cur_byte[bit_q];
      default: uart_tx = 1'b1;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule
